button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 87 ++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, symmetric debounce FSM,
// registered level, one-cycle press/release pulses and a press toggle.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clkin,
    input  logic greset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic toggle
);

    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic [19:0] cnt;

    always_ff @(posedge clkin or posedge greset) begin
        if (greset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            toggle    <= 1'b0;
        end else begin
            s1       <= btn_in;
            s2       <= s1;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= ARM_HIGH;
                        cnt   <= '0;
                    end
                end
                ARM_HIGH: begin
                    // A dip back to 0 abandons the press silently
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state     <= HIGH;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                        toggle    <= ~toggle;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= ARM_LOW;
                        cnt   <= '0;
                    end
                end
                ARM_LOW: begin
                    // btn_level stays 1 here until the release is confirmed
                    if (s2) begin
                        state <= HIGH;
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
